// File: rtl/regfile_wr_arbiter.sv
// regfile_wr_arbiter: round-robin write-port arbiter that registers one-hot row enables and data for the register array
// Ports: clk, reset (async, active-high); req_valid/req_addr/req_data in, req_ready out (one-hot-or-zero grant);
//        stall blocks all grants; wr_valid/wr_addr/wr_data/wr_en registered write to the array; last_grant registered winner.
// Macro WR_ARB_ZERO_REG_EN: writes to address 31 are accepted but never enable a row.
module regfile_wr_arbiter #(
    parameter int NREQ   = 2,
    parameter int DATA_W = 64,
    parameter int NREGS  = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ*5-1:0]        req_addr,
    input  logic [NREQ*DATA_W-1:0]   req_data,
    output logic [NREQ-1:0]          req_ready,
    input  logic                     stall,
    output logic                     wr_valid,
    output logic [4:0]               wr_addr,
    output logic [DATA_W-1:0]        wr_data,
    output logic [NREGS-1:0]         wr_en,
    output logic [NREQ-1:0]          last_grant
);
    localparam int PW = $clog2(NREQ);
    logic [PW-1:0]    rr_ptr;
    logic [PW-1:0]    win;
    logic [PW-1:0]    idx;
    logic             found;
    logic [4:0]       sel_addr;
    logic [NREGS-1:0] sel_en;
    // Scan from the requester after the last winner; first valid one wins.
    always_comb begin
        req_ready = '0;
        win = '0;
        idx = '0;
        found = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = PW'((int'(rr_ptr) + k) % NREQ);
            if (!stall && !found && req_valid[idx]) begin
                req_ready[idx] = 1'b1;
                win = idx;
                found = 1'b1;
            end
        end
    end
    assign sel_addr = req_addr[5*win +: 5];
`ifdef WR_ARB_ZERO_REG_EN
    assign sel_en = (int'(sel_addr) < NREGS && sel_addr != 5'd31) ? NREGS'(1) << sel_addr : '0;
`else
    assign sel_en = (int'(sel_addr) < NREGS) ? NREGS'(1) << sel_addr : '0;
`endif
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr     <= PW'(NREQ - 1);
            wr_valid   <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            wr_en      <= '0;
            last_grant <= '0;
        end else if (found) begin
            rr_ptr     <= win;
            wr_valid   <= 1'b1;
            wr_addr    <= sel_addr;
            wr_data    <= req_data[DATA_W*win +: DATA_W];
            wr_en      <= sel_en;
            last_grant <= req_ready;
        end else begin
            wr_valid   <= 1'b0;
            wr_en      <= '0;
        end
    end
endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// tb_regfile_wr_arbiter: directed and randomized checks of regfile_wr_arbiter against a behavioural model
module tb_regfile_wr_arbiter;
    localparam int N = 2;
    logic          clk = 1'b0;
    logic          reset;
    logic [N-1:0]  req_valid;
    logic [N*5-1:0] req_addr;
    logic [N*64-1:0] req_data;
    logic [N-1:0]  req_ready;
    logic          stall;
    logic          wr_valid;
    logic [4:0]    wr_addr;
    logic [63:0]   wr_data;
    logic [31:0]   wr_en;
    logic [N-1:0]  last_grant;

    regfile_wr_arbiter #(.NREQ(N), .DATA_W(64), .NREGS(32)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_addr(req_addr),
        .req_data(req_data), .req_ready(req_ready), .stall(stall), .wr_valid(wr_valid),
        .wr_addr(wr_addr), .wr_data(wr_data), .wr_en(wr_en), .last_grant(last_grant)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int rr;
    logic        m_valid;
    logic [4:0]  m_addr;
    logic [63:0] m_data;
    logic [31:0] m_en;
    logic [N-1:0] m_lg;
    logic [N-1:0] pend;
    logic [4:0]  paddr [N];
    logic [63:0] pdata [N];
    int g;
    int cnt [N];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] en_of(input logic [4:0] a);
`ifdef WR_ARB_ZERO_REG_EN
        if (a == 5'd31) return 32'h0;
`endif
        return 32'h1 << a;
    endfunction

    // Winner = valid requester at the smallest circular distance after rr.
    function automatic int exp_grant();
        int best = -1;
        int bestd = N;
        for (int i = 0; i < N; i++)
            if (req_valid[i] && !stall && ((i - rr - 1 + N) % N) < bestd) begin
                bestd = (i - rr - 1 + N) % N;
                best = i;
            end
        return best;
    endfunction

    task automatic model_reset();
        rr = N - 1;
        m_valid = 1'b0;
        m_addr = '0;
        m_data = '0;
        m_en = '0;
        m_lg = '0;
    endtask

    task automatic check_regs(input string tag);
        chk({tag, "_wr_valid"}, 128'(wr_valid), 128'(m_valid));
        chk({tag, "_wr_addr"}, 128'(wr_addr), 128'(m_addr));
        chk({tag, "_wr_data"}, 128'(wr_data), 128'(m_data));
        chk({tag, "_wr_en"}, 128'(wr_en), 128'(m_en));
        chk({tag, "_last_grant"}, 128'(last_grant), 128'(m_lg));
    endtask

    // Called just after a posedge with inputs already driven; returns the granted index or -1.
    task automatic cycle(input string tag, output int gi);
        logic [4:0]  a;
        logic [63:0] d;
        #1;
        gi = exp_grant();
        chk({tag, "_ready"}, 128'(req_ready), gi < 0 ? 128'(0) : 128'(1) << gi);
        if (gi >= 0) begin
            a = req_addr[5*gi +: 5];
            d = req_data[64*gi +: 64];
        end
        @(posedge clk);
        if (gi >= 0) begin
            m_valid = 1'b1;
            m_addr = a;
            m_data = d;
            m_en = en_of(a);
            m_lg = N'(1) << gi;
            rr = gi;
        end else begin
            m_valid = 1'b0;
            m_en = '0;
        end
        #1;
        check_regs(tag);
    endtask

    task automatic drive(input logic [N-1:0] v, input logic [4:0] a0, input logic [63:0] d0,
                         input logic [4:0] a1, input logic [63:0] d1, input logic s);
        req_valid = v;
        req_addr = {a1, a0};
        req_data = {d1, d0};
        stall = s;
    endtask

    initial begin
        model_reset();
        reset = 1'b1;
        drive(2'b00, 5'd0, 64'd0, 5'd0, 64'd0, 1'b0);
        #3;
        check_regs("reset");
        chk("reset_ready_idle", 128'(req_ready), 128'(0));
        #9 reset = 1'b0;
        @(posedge clk);
        #1;
        // Single requester
        drive(2'b01, 5'd5, 64'hDEADBEEF_00000001, 5'd0, 64'd0, 1'b0);
        cycle("single", g);
        chk("single_en_const", 128'(wr_en), 128'(32'h0000_0020));
        chk("single_data_const", 128'(wr_data), 128'(64'hDEADBEEF_00000001));
        // Reset to restore requester-0 priority, then round-robin
        reset = 1'b1;
        #1;
        model_reset();
        reset = 1'b0;
        drive(2'b11, 5'd1, 64'h1111, 5'd2, 64'h2222, 1'b0);
        for (int c = 0; c < 4; c++) begin
            cycle("rr", g);
            chk("rr_order", 128'(g), 128'(c % 2));
            chk("rr_en_const", 128'(wr_en), (c % 2) == 0 ? 128'(32'h2) : 128'(32'h4));
        end
        // Stall holds the pointer
        drive(2'b11, 5'd1, 64'h1111, 5'd2, 64'h2222, 1'b1);
        for (int c = 0; c < 2; c++) begin
            cycle("stall", g);
            chk("stall_ready_const", 128'(req_ready), 128'(0));
        end
        stall = 1'b0;
        cycle("resume", g);
        chk("resume_grant", 128'(g), 128'(0));
        // Zero register
        drive(2'b10, 5'd0, 64'd0, 5'd31, 64'hCAFE, 1'b0);
        cycle("xzr", g);
`ifdef WR_ARB_ZERO_REG_EN
        chk("xzr_en_const", 128'(wr_en), 128'(0));
`else
        chk("xzr_en_const", 128'(wr_en), 128'(32'h8000_0000));
`endif
        chk("xzr_valid_const", 128'(wr_valid), 128'(1));
        // Fairness over continuous requests
        drive(2'b11, 5'd7, 64'h7, 5'd9, 64'h9, 1'b0);
        cnt[0] = 0;
        cnt[1] = 0;
        for (int c = 0; c < 2 * N; c++) begin
            cycle("fair", g);
            if (g >= 0) cnt[g]++;
        end
        chk("fair_0", 128'(cnt[0]), 128'(2));
        chk("fair_1", 128'(cnt[1]), 128'(2));
        // Randomized traffic with held requests
        pend = '0;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++)
                if (!pend[i] && ($urandom % 3) != 0) begin
                    pend[i] = 1'b1;
                    paddr[i] = 5'($urandom_range(0, 31));
                    pdata[i] = {$urandom, $urandom};
                end
            drive(pend, paddr[0], pdata[0], paddr[1], pdata[1], ($urandom % 6) == 0);
            cycle("rand", g);
            if (g >= 0) pend[g] = 1'b0;
        end
        // Async reset mid-cycle with a registered write pending
        drive(2'b11, 5'd3, 64'h33, 5'd4, 64'h44, 1'b0);
        cycle("pre_reset", g);
        #2 reset = 1'b1;
        #1;
        model_reset();
        check_regs("async_reset");
        chk("async_reset_wr_en", 128'(wr_en), 128'(0));
        #1 reset = 1'b0;
        cycle("post_reset", g);
        chk("post_reset_grant", 128'(g), 128'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
